// File: rtl/adc_scan_pkg.sv
// Shared types and widths for the dual-ADC scan sequencer.
package adc_scan_pkg;

  localparam int unsigned ADC_DATA_W = 12;
  localparam int unsigned ADC_CH_W   = 5;
  localparam int unsigned FILT_W     = 14;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StWait,
    StStore
  } scan_state_e;

endpackage

// File: rtl/adc_scan_filter.sv
// Per-slot/port IIR smoother, y <- y + ((x<<2) - y)>>>2 in 12.2 fixed point.
// Only exists when ADC_SCAN_AVG_EN is defined.
`ifdef ADC_SCAN_AVG_EN
module adc_scan_filter
  import adc_scan_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [ADC_DATA_W-1:0] i_x,
  output logic [ADC_DATA_W-1:0] o_y
);

  logic [FILT_W-1:0]        r_y;
  logic                     r_primed;
  logic signed [FILT_W+1:0] w_diff;
  logic [FILT_W-1:0]        w_step;

  assign w_diff = $signed({2'b00, i_x, 2'b00}) - $signed({2'b00, r_y});
  // The shifted difference always fits in FILT_W signed bits.
  assign w_step = FILT_W'(w_diff >>> 2);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_y      <= '0;
      r_primed <= 1'b0;
    end else if (i_load) begin
      r_primed <= 1'b1;
      r_y      <= r_primed ? r_y + w_step : {i_x, 2'b00};
    end
  end

  assign o_y = r_y[FILT_W-1:2];

endmodule
`endif

// File: rtl/adc_scan_ctrl.sv
// Round-robin scan sequencer driving both ADC command ports in lockstep.
// Define ADC_SCAN_AVG_EN to smooth stored samples through adc_scan_filter.
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int unsigned N_SLOTS = 4,
  parameter int unsigned CH_BASE = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                          clock_clk,
  input  logic                          reset_sink_reset,
  input  logic                          enable,
  output logic                          command_valid,
  output logic [ADC_CH_W-1:0]           command_channel,
  output logic                          command_startofpacket,
  output logic                          command_endofpacket,
  input  logic                          command_ready,
  output logic                          command_2_valid,
  output logic [ADC_CH_W-1:0]           command_2_channel,
  output logic                          command_2_startofpacket,
  output logic                          command_2_endofpacket,
  input  logic                          command_2_ready,
  input  logic                          response_valid,
  input  logic [ADC_CH_W-1:0]           response_channel,
  input  logic [ADC_DATA_W-1:0]         response_data,
  input  logic                          response_2_valid,
  input  logic [ADC_CH_W-1:0]           response_2_channel,
  input  logic [ADC_DATA_W-1:0]         response_2_data,
  output logic [ADC_DATA_W*N_SLOTS-1:0] samples_a,
  output logic [ADC_DATA_W*N_SLOTS-1:0] samples_b,
  output logic                          sample_strobe,
  output logic [3:0]                    sample_slot,
  output logic                          scan_done,
  output logic                          err_timeout,
  output logic                          err_mismatch
);

  localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  LAST_SLOT = 4'(N_SLOTS - 1);

  scan_state_e           r_state;
  logic [3:0]            r_slot;
  logic [ADC_CH_W-1:0]   r_channel;
  logic                  r_valid_a, r_valid_b;
  logic                  r_got_a, r_got_b;
  logic [ADC_DATA_W-1:0] r_lat_a, r_lat_b;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_strobe, r_scan_done, r_err_to, r_err_mm;
  logic [3:0]            r_sample_slot;

  logic                  w_listen_a, w_listen_b, w_hit_a, w_hit_b, w_miss_a, w_miss_b;
  logic                  w_got_a, w_got_b, w_done_a, w_done_b;
  logic [3:0]            w_slot_nxt;
  logic [ADC_CH_W-1:0]   w_ch_nxt;

  // A port listens for its response as soon as its own command is accepted.
  assign w_listen_a = (r_state == StWait) || (r_state == StCmd && !r_valid_a);
  assign w_listen_b = (r_state == StWait) || (r_state == StCmd && !r_valid_b);
  assign w_hit_a    = w_listen_a && response_valid && (response_channel == r_channel);
  assign w_hit_b    = w_listen_b && response_2_valid && (response_2_channel == r_channel);
  assign w_miss_a   = w_listen_a && response_valid && (response_channel != r_channel);
  assign w_miss_b   = w_listen_b && response_2_valid && (response_2_channel != r_channel);
  assign w_got_a    = r_got_a | w_hit_a;
  assign w_got_b    = r_got_b | w_hit_b;
  assign w_done_a   = !r_valid_a || command_ready;
  assign w_done_b   = !r_valid_b || command_2_ready;
  assign w_slot_nxt = (r_slot == LAST_SLOT) ? 4'd0 : r_slot + 4'd1;
  assign w_ch_nxt   = ADC_CH_W'(CH_BASE) + {1'b0, w_slot_nxt};

  always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      r_state       <= StIdle;
      r_slot        <= '0;
      r_channel     <= '0;
      r_valid_a     <= 1'b0;
      r_valid_b     <= 1'b0;
      r_got_a       <= 1'b0;
      r_got_b       <= 1'b0;
      r_lat_a       <= '0;
      r_lat_b       <= '0;
      r_cnt         <= '0;
      r_strobe      <= 1'b0;
      r_scan_done   <= 1'b0;
      r_err_to      <= 1'b0;
      r_err_mm      <= 1'b0;
      r_sample_slot <= '0;
    end else begin
      r_strobe    <= 1'b0;
      r_scan_done <= 1'b0;
      if (w_hit_a) begin
        r_got_a <= 1'b1;
        r_lat_a <= response_data;
      end
      if (w_hit_b) begin
        r_got_b <= 1'b1;
        r_lat_b <= response_2_data;
      end
      if (w_miss_a || w_miss_b) r_err_mm <= 1'b1;

      unique case (r_state)
        StIdle: begin
          if (enable) begin
            r_state   <= StCmd;
            r_slot    <= '0;
            r_channel <= ADC_CH_W'(CH_BASE);
            r_valid_a <= 1'b1;
            r_valid_b <= 1'b1;
            r_got_a   <= 1'b0;
            r_got_b   <= 1'b0;
          end
        end
        StCmd: begin
          if (command_ready)   r_valid_a <= 1'b0;
          if (command_2_ready) r_valid_b <= 1'b0;
          if (w_done_a && w_done_b) begin
            r_state <= StWait;
            r_cnt   <= '0;
          end
        end
        StWait: begin
          if (w_got_a && w_got_b) begin
            r_state <= StStore;
          end else if (r_cnt == CNT_W'(TIMEOUT)) begin
            r_state  <= StStore;
            r_err_to <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StStore: begin
          r_strobe      <= 1'b1;
          r_sample_slot <= r_slot;
          r_scan_done   <= (r_slot == LAST_SLOT);
          r_slot        <= w_slot_nxt;
          if (enable) begin
            r_state   <= StCmd;
            r_channel <= w_ch_nxt;
            r_valid_a <= 1'b1;
            r_valid_b <= 1'b1;
            r_got_a   <= 1'b0;
            r_got_b   <= 1'b0;
          end else begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef ADC_SCAN_AVG_EN
  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_filt
    logic w_wr_a, w_wr_b;
    assign w_wr_a = (r_state == StStore) && (r_slot == 4'(gi)) && r_got_a;
    assign w_wr_b = (r_state == StStore) && (r_slot == 4'(gi)) && r_got_b;
    adc_scan_filter u_filt_a (
      .i_clk  (clock_clk),
      .i_rst  (reset_sink_reset),
      .i_load (w_wr_a),
      .i_x    (r_lat_a),
      .o_y    (samples_a[ADC_DATA_W*gi +: ADC_DATA_W])
    );
    adc_scan_filter u_filt_b (
      .i_clk  (clock_clk),
      .i_rst  (reset_sink_reset),
      .i_load (w_wr_b),
      .i_x    (r_lat_b),
      .o_y    (samples_b[ADC_DATA_W*gi +: ADC_DATA_W])
    );
  end
`else
  logic [ADC_DATA_W-1:0] r_samp_a [N_SLOTS];
  logic [ADC_DATA_W-1:0] r_samp_b [N_SLOTS];

  // A port that timed out keeps its previous sample.
  always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        r_samp_a[i] <= '0;
        r_samp_b[i] <= '0;
      end
    end else if (r_state == StStore) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (r_slot == 4'(i)) begin
          if (r_got_a) r_samp_a[i] <= r_lat_a;
          if (r_got_b) r_samp_b[i] <= r_lat_b;
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_pack
    assign samples_a[ADC_DATA_W*gi +: ADC_DATA_W] = r_samp_a[gi];
    assign samples_b[ADC_DATA_W*gi +: ADC_DATA_W] = r_samp_b[gi];
  end
`endif

  assign command_valid           = r_valid_a;
  assign command_2_valid         = r_valid_b;
  assign command_channel         = r_channel;
  assign command_2_channel       = r_channel;
  assign command_startofpacket   = 1'b1;
  assign command_endofpacket     = 1'b1;
  assign command_2_startofpacket = 1'b1;
  assign command_2_endofpacket   = 1'b1;
  assign sample_strobe           = r_strobe;
  assign sample_slot             = r_sample_slot;
  assign scan_done               = r_scan_done;
  assign err_timeout             = r_err_to;
  assign err_mismatch            = r_err_mm;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Randomized bench for adc_scan_ctrl: the bench plays both ADCs and tracks the
// expected sample bank per slot, strobe timing and sticky error flags.
module tb_adc_scan_ctrl;

  localparam int N_SLOTS = 4;
  localparam int CH_BASE = 1;
  localparam int TIMEOUT = 10;

  logic                   clock_clk = 1'b0;
  logic                   reset_sink_reset;
  logic                   enable;
  logic                   command_valid, command_2_valid;
  logic [4:0]             command_channel, command_2_channel;
  logic                   command_startofpacket, command_endofpacket;
  logic                   command_2_startofpacket, command_2_endofpacket;
  logic                   command_ready, command_2_ready;
  logic                   response_valid, response_2_valid;
  logic [4:0]             response_channel, response_2_channel;
  logic [11:0]            response_data, response_2_data;
  logic [12*N_SLOTS-1:0]  samples_a, samples_b;
  logic                   sample_strobe;
  logic [3:0]             sample_slot;
  logic                   scan_done, err_timeout, err_mismatch;

  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_slot = 0;
  bit          exp_to   = 1'b0;
  bit          exp_mm   = 1'b0;
  logic [11:0] exp_a [N_SLOTS];
  logic [11:0] exp_b [N_SLOTS];

  adc_scan_ctrl #(
    .N_SLOTS (N_SLOTS),
    .CH_BASE (CH_BASE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock_clk               (clock_clk),
    .reset_sink_reset        (reset_sink_reset),
    .enable                  (enable),
    .command_valid           (command_valid),
    .command_channel         (command_channel),
    .command_startofpacket   (command_startofpacket),
    .command_endofpacket     (command_endofpacket),
    .command_ready           (command_ready),
    .command_2_valid         (command_2_valid),
    .command_2_channel       (command_2_channel),
    .command_2_startofpacket (command_2_startofpacket),
    .command_2_endofpacket   (command_2_endofpacket),
    .command_2_ready         (command_2_ready),
    .response_valid          (response_valid),
    .response_channel        (response_channel),
    .response_data           (response_data),
    .response_2_valid        (response_2_valid),
    .response_2_channel      (response_2_channel),
    .response_2_data         (response_2_data),
    .samples_a               (samples_a),
    .samples_b               (samples_b),
    .sample_strobe           (sample_strobe),
    .sample_slot             (sample_slot),
    .scan_done               (scan_done),
    .err_timeout             (err_timeout),
    .err_mismatch            (err_mismatch)
  );

  always #5 clock_clk = ~clock_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12*N_SLOTS-1:0] pack_bank(input bit sel_b);
    logic [12*N_SLOTS-1:0] v;
    for (int i = 0; i < N_SLOTS; i++) v[12*i +: 12] = sel_b ? exp_b[i] : exp_a[i];
    return v;
  endfunction

  function automatic int pick_rm(input int r, input int limit);
    int v;
    if ($urandom_range(3, 0) != 0) return -1;
    v = int'($urandom_range(limit, 0));
    return (v == r) ? -1 : v;
  endfunction

  // One slot, called at a negedge. ra/rb = WAIT cycle of the correct response
  // (-1: never), rma/rmb = WAIT cycle of a wrong-channel response (-1: none).
  task automatic run_slot(input int da, input int db, input int ra, input int rb,
                          input int rma, input int rmb,
                          input logic [11:0] dva, input logic [11:0] dvb, input bit drop);
    bit         acc_a, acc_b;
    int         j, seen, exp_k;
    logic [4:0] ch;
    ch = 5'(CH_BASE + exp_slot);
    j  = 0;
    while (!command_valid && j < 20) begin
      @(negedge clock_clk);
      j++;
    end
    check_eq("cmd_start", command_valid, 1'b1);
    check_eq("cmd_ch_a", command_channel, ch);
    check_eq("cmd_ch_b", command_2_channel, ch);
    acc_a = 1'b0;
    acc_b = 1'b0;
    j     = 0;
    while (!(acc_a && acc_b)) begin
      check_eq("cmd_vld_a", command_valid, !acc_a);
      check_eq("cmd_vld_b", command_2_valid, !acc_b);
      command_ready   = (j >= da);
      command_2_ready = (j >= db);
      @(posedge clock_clk);
      if (j >= da) acc_a = 1'b1;
      if (j >= db) acc_b = 1'b1;
      @(negedge clock_clk);
      j++;
    end
    command_ready   = 1'b0;
    command_2_ready = 1'b0;
    check_eq("acc_vld_a", command_valid, 1'b0);
    check_eq("acc_vld_b", command_2_valid, 1'b0);

    exp_k = ((ra >= 0 && rb >= 0) ? ((ra > rb) ? ra : rb) : TIMEOUT) + 2;
    seen  = -1;
    for (int k = 0; k <= TIMEOUT + 6; k++) begin
      if (sample_strobe) begin
        seen = k;
        break;
      end
      response_valid     = (k == ra) || (k == rma);
      response_channel   = (k == ra) ? ch : (ch ^ 5'h05);
      response_data      = (k == ra) ? dva : 12'($urandom);
      response_2_valid   = (k == rb) || (k == rmb);
      response_2_channel = (k == rb) ? ch : (ch ^ 5'h05);
      response_2_data    = (k == rb) ? dvb : 12'($urandom);
      if (k == 0 && drop) enable = 1'b0;
      @(negedge clock_clk);
    end
    response_valid   = 1'b0;
    response_2_valid = 1'b0;

    if (ra >= 0) exp_a[exp_slot] = dva;
    if (rb >= 0) exp_b[exp_slot] = dvb;
    if (ra < 0 || rb < 0) exp_to = 1'b1;
    if (rma >= 0 || rmb >= 0) exp_mm = 1'b1;
    check_eq("strobe_cycle", 64'(seen), 64'(exp_k));
    if (seen >= 0) begin
      check_eq("sample_slot", sample_slot, 4'(exp_slot));
      check_eq("scan_done", scan_done, exp_slot == N_SLOTS - 1);
      check_eq("samples_a", samples_a, pack_bank(1'b0));
      check_eq("samples_b", samples_b, pack_bank(1'b1));
      check_eq("err_timeout", err_timeout, exp_to);
      check_eq("err_mismatch", err_mismatch, exp_mm);
      check_eq("next_cmd_vld", command_valid, enable);
    end
    exp_slot = (exp_slot + 1) % N_SLOTS;
  endtask

  // After an enable drop: stay idle, then restart from slot 0.
  task automatic restart();
    repeat (3) begin
      check_eq("idle_vld_a", command_valid, 1'b0);
      check_eq("idle_vld_b", command_2_valid, 1'b0);
      @(negedge clock_clk);
    end
    enable   = 1'b1;
    exp_slot = 0;
    @(negedge clock_clk);
    check_eq("en_latency", command_valid, 1'b1);
  endtask

  initial begin
    int ra, rb, lim;
    bit drop;
    reset_sink_reset = 1'b1;
    enable           = 1'b0;
    command_ready    = 1'b0;
    command_2_ready  = 1'b0;
    response_valid   = 1'b0;
    response_2_valid = 1'b0;
    response_channel   = '0;
    response_2_channel = '0;
    response_data      = '0;
    response_2_data    = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      exp_a[i] = '0;
      exp_b[i] = '0;
    end
    repeat (2) @(negedge clock_clk);

    check_eq("rst_vld_a", command_valid, 1'b0);
    check_eq("rst_vld_b", command_2_valid, 1'b0);
    check_eq("rst_ch", command_channel, 5'd0);
    check_eq("rst_samples_a", samples_a, '0);
    check_eq("rst_samples_b", samples_b, '0);
    check_eq("rst_strobe", sample_strobe, 1'b0);
    check_eq("rst_done", scan_done, 1'b0);
    check_eq("rst_errs", {err_timeout, err_mismatch}, 2'b00);
    check_eq("sop_eop", {command_startofpacket, command_endofpacket,
                         command_2_startofpacket, command_2_endofpacket}, 4'hF);

    reset_sink_reset = 1'b0;
    @(negedge clock_clk);
    check_eq("idle_no_cmd", command_valid, 1'b0);
    enable = 1'b1;
    @(negedge clock_clk);
    check_eq("en_latency", command_valid, 1'b1);

    // Directed first scan with recognisable data.
    for (int s = 0; s < N_SLOTS; s++)
      run_slot(0, 0, 3, 3, -1, -1, 12'(12'h100 + s), 12'(12'h200 + s), 1'b0);
    check_eq("scan1_a", samples_a, 48'h103102101100);
    check_eq("scan1_b", samples_b, 48'h203202201200);

    run_slot(0, 0, 2, -1, -1, -1, 12'hABC, 12'hDEF, 1'b0);  // ADC 2 silent
    run_slot(0, 0, 4, 2, 1, -1, 12'h123, 12'h456, 1'b0);    // channel 7 while expecting 2
    run_slot(5, 0, 1, 1, -1, -1, 12'h321, 12'h654, 1'b0);   // ADC 1 ready stalled
    run_slot(0, 0, 2, 3, -1, -1, 12'h777, 12'h888, 1'b1);   // enable dropped in WAIT
    restart();

    for (int n = 0; n < 40; n++) begin
      ra   = ($urandom_range(4, 0) == 0) ? -1 : int'($urandom_range(8, 0));
      rb   = ($urandom_range(4, 0) == 0) ? -1 : int'($urandom_range(8, 0));
      lim  = (ra >= 0 && rb >= 0) ? ((ra > rb) ? ra : rb) : TIMEOUT;
      drop = ($urandom_range(7, 0) == 0);
      run_slot(int'($urandom_range(4, 0)), int'($urandom_range(4, 0)), ra, rb,
               pick_rm(ra, lim), pick_rm(rb, lim), 12'($urandom), 12'($urandom), drop);
      if (drop) restart();
    end

    // Asynchronous reset while a command is pending.
    check_eq("pre_rst_vld", command_valid, 1'b1);
    #2 reset_sink_reset = 1'b1;
    #1;
    check_eq("arst_vld", {command_valid, command_2_valid}, 2'b00);
    check_eq("arst_samples", {samples_a, samples_b}, '0);
    check_eq("arst_flags", {sample_strobe, scan_done, err_timeout, err_mismatch}, 4'h0);
    @(negedge clock_clk);
    reset_sink_reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Autonomous scan sequencer for the dual-ADC core. It steps round-robin through a fixed list of channel slots and issues one command per slot on both ADC command ports in lockstep. It collects the two tagged responses and keeps the latest 12-bit sample per slot and ADC in an output register bank for the game logic (joystick/paddle reads). Handshake stalls, channel mismatches and lost responses are handled without blocking the scan.

## Interface
- `N_SLOTS`, default 4: slots per scan (1..16); slot i samples channel `CH_BASE + i` on both ADCs.
- `CH_BASE`, default 1: first ADC channel number (5-bit).
- `TIMEOUT`, default 255: cycles to wait in WAIT before abandoning a slot (≥ 2).
- `clock_clk` in 1: single clock, same clock as the ADC core's `clock_clk`.
- `reset_sink_reset` in 1: asynchronous, active-high reset.
- `enable` in 1: level; scanning runs while high.
- `command_valid`, `command_2_valid` out 1: command request, ADC 1 / ADC 2.
- `command_channel`, `command_2_channel` out 5: channel of the current slot.
- `command_startofpacket`, `command_endofpacket`, and the `_2` copies, out 1: tied 1.
- `command_ready`, `command_2_ready` in 1: command accepted.
- `response_valid`, `response_2_valid` in 1: response strobe.
- `response_channel`, `response_2_channel` in 5: response tag.
- `response_data`, `response_2_data` in 12: conversion result.
- `samples_a`, `samples_b` out `12*N_SLOTS`: slot i occupies bits `[12*i+11:12*i]`.
- `sample_strobe` out 1: one-cycle pulse when a slot's samples update.
- `sample_slot` out 4: slot index that `sample_strobe` refers to.
- `scan_done` out 1: one-cycle pulse after the last slot is stored.
- `err_timeout`, `err_mismatch` out 1: sticky flags, cleared only by reset.

## Operation
- FSM states: IDLE, CMD, WAIT, STORE.
- IDLE: all command_valid low. `enable`=1 → CMD with slot=0.
- CMD: each port's valid is held high until its own ready is seen in the same cycle (per-port done flag). Once both are done → WAIT, timeout counter cleared.
- WAIT: a response_valid whose channel equals the current slot's channel latches that port's data and sets a got flag.
  - A response_valid with a different channel is dropped and sets `err_mismatch`.
  - Both got flags set → STORE.
  - If the counter reaches TIMEOUT first → STORE. Missing ports keep their previous value, and `err_timeout` is set.
- STORE: writes the latched data for the slot, pulses `sample_strobe`, and advances the slot.
  - If the slot was N_SLOTS-1, it wraps to 0 and `scan_done` pulses.
  - Next state is CMD if `enable`=1, else IDLE.
- `enable` falling mid-slot: the current slot completes (including timeout) before IDLE. A command is never withdrawn once valid is asserted.
- Responses arriving in CMD (port already done) are accepted as in WAIT.
- Both ports responding in the same cycle: both are latched.

## Timing
- Reset values: all outputs 0 (samples 0, flags 0, command_valid 0), state IDLE, slot 0. SOP/EOP outputs read 1.
- `enable` high at edge n → command_valid high from cycle n+1.
- With ready high immediately: CMD lasts 1 cycle.
- STORE lasts 1 cycle. `samples_*` and `sample_strobe` update on the same edge.
- Slot period = CMD cycles + WAIT cycles + 1. Back-to-back scan: a new command starts the cycle after STORE.
- Timeout: STORE entered on the cycle after the counter equals TIMEOUT.

## Configuration
- `ADC_SCAN_AVG_EN` defined: each slot/port holds a 14-bit filter state `y` (12.2 fixed point), updated in STORE as `y ← y + ((x<<2) − y)>>>2` (signed difference, arithmetic shift).
  - Output = `y[13:2]`.
  - On the first sample after reset, `y = x<<2`.
  - Timed-out ports are not updated.
- Not defined: output = raw latched sample; no filter registers exist.

## Structure
- Package `adc_scan_pkg`: the state enum, `ADC_DATA_W=12`, `ADC_CH_W=5`, `FILT_W=14`.
- Sub-module `adc_scan_filter`: one instance per slot/port, compiled only under `ADC_SCAN_AVG_EN`.
- Everything else lives in a single module.

## Test plan
- Ready and response after 3 cycles, N_SLOTS=4, data = 0x100+slot on ADC 1 and 0x200+slot on ADC 2 → after `scan_done`, samples_a = {0x103,0x102,0x101,0x100} and samples_b = {0x203,…,0x200}; commands carry channels 1,2,3,4.
- command_ready held low 5 cycles, command_2_ready immediate → command_2_valid drops after 1 cycle; command_valid stays high until ready. No WAIT before both are accepted.
- ADC 2 never responds, TIMEOUT=10 → STORE 11 cycles after entering WAIT; `err_timeout`=1; samples_b slot unchanged; scan continues to the next slot.
- Response with channel 7 while expecting 2 → dropped, `err_mismatch`=1, still waiting; the correct response then completes the slot.
- `enable` dropped during WAIT of slot 1 → slot 1 stored, then IDLE with command_valid low. Reset asserted mid-CMD → all outputs 0 asynchronously.
- With `ADC_SCAN_AVG_EN`: constant input 0x400 → output 0x400. Step to 0x800 → outputs 0x500, 0x5C0, 0x650.
